rtsnoc_rx_fifo: RTL and testbench
=================================

Name: rtsnoc_rx_fifo

Overview:
- Receive-side flit buffer between the RTSNoC router local port and the NoC wishbone slave. The slave connects to its router-facing inputs.
- Drains incoming flits from the router as soon as space exists, so the router is not stalled while software services the slave.
- Presents the oldest stored flit to the slave with the same nd/rd handshake the router uses.
- Guarantees one clean nd rising edge per flit, so the slave's edge-detect interrupt fires once per flit.

Parameters:
- DEPTH_LOG2, 3, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2 entries); legal range 1..6.
- BUS_WIDTH, 38, flit width (header + data), matching the router local-port bus.

Ports:
- clk_i  in  1  sole clock; all logic on rising edge.
- rst_n_i  in  1  reset; synchronous, active-low.
- rtr_dout_i  in  BUS_WIDTH  flit from router local port.
- rtr_nd_i  in  1  router has a flit valid on rtr_dout_i.
- rtr_rd_o  out  1  one-cycle acknowledge to router; flit has been captured.
- cpu_dout_o  out  BUS_WIDTH  head flit, to the slave's noc_dout_i.
- cpu_nd_o  out  1  head flit valid, to the slave's noc_nd_i.
- cpu_rd_i  in  1  pop request from the slave's noc_rd_o; level-sensitive source, edge-detected here.
- level_o  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- full_o  out  1  level_o == DEPTH.

Behaviour:
- Reset (rst_n_i=0 at a clock edge):
  - Outputs: rtr_rd_o=0, cpu_nd_o=0, level_o=0, full_o=0, cpu_dout_o=0.
  - Internal state: wr_ptr=rd_ptr=0, cpu_rd_q=0, ingress FSM=IDLE.
  - Reset asserted mid-handshake drops rtr_rd_o at that edge and discards all stored flits.
  - Memory contents need no reset.
- Ingress FSM, states IDLE, ACK, GAP:
  - IDLE: if rtr_nd_i=1 and pre-pop level < DEPTH at edge N:
    - write rtr_dout_i to mem[wr_ptr]; wr_ptr+1 mod DEPTH; level+1.
    - go to ACK.
    - Otherwise stay in IDLE.
  - ACK: rtr_rd_o=1 for exactly this cycle (cycle N+1); go to GAP unconditionally.
  - GAP: rtr_rd_o=0; rtr_nd_i is ignored; go to IDLE. The router must have dropped nd or presented its next flit by the end of GAP.
  - Maximum ingress rate is 1 flit per 3 cycles.
  - rtr_rd_o is 0 in IDLE and GAP.
- Full:
  - No capture and no rtr_rd_o; the router holds its flit.
  - A pop at edge N does not enable capture at edge N. Capture happens at the first edge where the pre-pop level < DEPTH, i.e. N+1 at the earliest.
- Pop:
  - pop = cpu_rd_i & ~cpu_rd_q; cpu_rd_q <= cpu_rd_i every cycle.
  - If pop and level>0: rd_ptr+1 mod DEPTH; level-1.
  - If pop and level=0: ignored; no pointer or level change.
  - If cpu_rd_i is held high for multiple cycles: exactly one pop.
- Simultaneous capture and pop at the same edge: level unchanged; both pointers advance.
- cpu_nd_o (registered):
  - Following an edge with an effective pop: cpu_nd_o=0 for one cycle, regardless of level.
  - Otherwise: cpu_nd_o = (level != 0), using the post-update level.
  - A flit captured into an empty FIFO at edge N gives cpu_nd_o=1 from edge N+1.
- cpu_dout_o = mem[rd_ptr] when level != 0, else 0.
- level_o and full_o are registered and reflect post-update values.
- Pointers are DEPTH_LOG2 bits and wrap naturally. Empty/full are decided by level, never by pointer compare.
- Level never exceeds DEPTH and never underflows; there is no overflow path, because backpressure is via withheld rtr_rd_o.

Test Plan:
- Reset then single flit: rtr_dout_i=38'h2_1234_5678 with rtr_nd_i=1, held until rtr_rd_o.
  - Expected: rtr_rd_o high exactly 1 cycle, the cycle after capture.
  - Expected: cpu_nd_o=1 and cpu_dout_o=38'h2_1234_5678 from the cycle after capture; level_o=1.
- Fill (DEPTH=8): router streams 10 flits 0..9.
  - Expected: 8 acks; full_o=1; flit 8 held with rtr_rd_o=0.
  - Then one cpu_rd_i pulse → flit 8 captured one edge after the pop edge, level_o back to 8; cpu_dout_o=1.
- Drain: with 3 flits stored, cpu_rd_i held high for 5 cycles.
  - Expected: exactly one pop; level_o=2.
  - Expected: cpu_nd_o low 1 cycle, then high with the next flit.
- Pop on empty: cpu_rd_i pulse with level 0 → level_o=0, no pointer change; the next captured flit reads back correctly.
- Pointer wrap plus simultaneous events:
  - Push/pop 20 flits with a pop edge coinciding with a capture edge.
  - Expected: level unchanged on that edge; output order equals input order across wrap.
- Reset mid-ACK: assert rst_n_i=0 during the rtr_rd_o cycle with 4 flits stored.
  - Expected: next cycle rtr_rd_o=0, cpu_nd_o=0, level_o=0.

Source files
------------

// File: rtl/rtsnoc_rx_fifo.sv
// rtl/rtsnoc_rx_fifo.sv - receive-side flit FIFO between RTSNoC router local port and NoC slave
//
// Purpose:
//   Captures flits from the router local port as soon as space exists, so the
//   router is not stalled while software services the slave. The oldest stored
//   flit is presented to the slave with the router-style nd/rd handshake. Each
//   pop forces cpu_nd_o low for one cycle so every flit produces exactly one
//   rising edge on cpu_nd_o.
//
// Ports:
//   clk_i       sole clock, rising edge
//   rst_n_i     synchronous active-low reset
//   rtr_dout_i  flit from the router local port
//   rtr_nd_i    router has a flit valid on rtr_dout_i
//   rtr_rd_o    one-cycle acknowledge to the router (flit captured)
//   cpu_dout_o  head flit to the slave (0 when empty)
//   cpu_nd_o    head flit valid to the slave
//   cpu_rd_i    pop request from the slave, level signal, edge-detected here
//   level_o     current occupancy, 0..DEPTH
//   full_o      level_o == DEPTH

module rtsnoc_rx_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int BUS_WIDTH  = 38
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [BUS_WIDTH-1:0]  rtr_dout_i,
  input  logic                  rtr_nd_i,
  output logic                  rtr_rd_o,
  output logic [BUS_WIDTH-1:0]  cpu_dout_o,
  output logic                  cpu_nd_o,
  input  logic                  cpu_rd_i,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  full_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] LEVEL_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_GAP
  } ing_state_t;

  ing_state_t               state_q;
  ing_state_t               state_d;

  logic [BUS_WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0]    wr_ptr_q;
  logic [DEPTH_LOG2-1:0]    rd_ptr_q;
  logic [DEPTH_LOG2:0]      level_q;
  logic [DEPTH_LOG2:0]      level_d;
  logic                     cpu_rd_q;
  logic                     cpu_nd_q;
  logic                     full_q;

  logic                     capture;
  logic                     pop_edge;
  logic                     pop_eff;

  // Slave holds noc_rd as a level; only its rising edge pops.
  assign pop_edge = cpu_rd_i & ~cpu_rd_q;
  assign pop_eff  = pop_edge & (level_q != LEVEL_ZERO);

  // Ingress FSM. Capture uses the pre-pop level, so a pop on the same edge
  // cannot make room for a capture on that edge.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rtr_nd_i && (level_q != LEVEL_FULL)) begin
          capture = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_GAP;
      // GAP gives the router one cycle to drop nd or present its next flit.
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({capture, pop_eff})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cpu_rd_q <= 1'b0;
      cpu_nd_q <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cpu_rd_q <= cpu_rd_i;
      level_q  <= level_d;
      full_q   <= (level_d == LEVEL_FULL);
      if (capture) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_eff) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      // A pop forces one low cycle so the slave sees a fresh rising edge
      // for the next flit even when the FIFO stays non-empty.
      cpu_nd_q <= ~pop_eff & (level_d != LEVEL_ZERO);
    end
  end

  // Storage is not reset; occupancy tracking makes stale contents invisible.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && capture) begin
      mem[wr_ptr_q] <= rtr_dout_i;
    end
  end

  assign rtr_rd_o   = (state_q == ST_ACK);
  assign cpu_nd_o   = cpu_nd_q;
  assign cpu_dout_o = (level_q != LEVEL_ZERO) ? mem[rd_ptr_q] : '0;
  assign level_o    = level_q;
  assign full_o     = full_q;

endmodule

// File: tb/tb_rtsnoc_rx_fifo.sv
// tb/tb_rtsnoc_rx_fifo.sv - directed self-checking bench for rtsnoc_rx_fifo

module tb_rtsnoc_rx_fifo;

  localparam int DL2 = 3;
  localparam int BW  = 38;

  logic          clk;
  logic          rst_n;
  logic [BW-1:0] rtr_dout;
  logic          rtr_nd;
  logic          rtr_rd;
  logic [BW-1:0] cpu_dout;
  logic          cpu_nd;
  logic          cpu_rd;
  logic [DL2:0]  level;
  logic          full;

  int n_checks = 0;
  int n_fail   = 0;

  rtsnoc_rx_fifo #(.DEPTH_LOG2(DL2), .BUS_WIDTH(BW)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .rtr_dout_i (rtr_dout),
    .rtr_nd_i   (rtr_nd),
    .rtr_rd_o   (rtr_rd),
    .cpu_dout_o (cpu_dout),
    .cpu_nd_o   (cpu_nd),
    .cpu_rd_i   (cpu_rd),
    .level_o    (level),
    .full_o     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n;
    logic          nd;
    logic [BW-1:0] din;
    logic          rd;
    logic          e_rtr_rd;
    logic          e_cpu_nd;
    logic [DL2:0]  e_level;
    logic          e_full;
    logic [BW-1:0] e_dout;
  } vec_t;

  vec_t vecs[15];
  logic [BW-1:0] sb[$];

  function automatic vec_t mk(logic r, logic n, logic [BW-1:0] d, logic c,
                              logic er, logic en, logic [DL2:0] el, logic ef,
                              logic [BW-1:0] ed);
    vec_t v;
    v.rst_n = r; v.nd = n; v.din = d; v.rd = c;
    v.e_rtr_rd = er; v.e_cpu_nd = en; v.e_level = el; v.e_full = ef; v.e_dout = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Router model: presents a flit until acknowledged, then drops nd.
  task automatic push_flit(input logic [BW-1:0] d);
    logic acked;
    acked = 1'b0;
    rtr_nd = 1'b1;
    rtr_dout = d;
    for (int i = 0; i < 20 && !acked; i++) begin
      step();
      if (rtr_rd) acked = 1'b1;
    end
    rtr_nd = 1'b0;
    check("push_ack", acked, 1'b1);
    if (acked) sb.push_back(d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rtr_nd = 1'b0; cpu_rd = 1'b0; rtr_dout = '0;
    step();
    step();
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic settle();
    rtr_nd = 1'b0; cpu_rd = 1'b0;
    step();
    step();
  endtask

  initial begin
    int acks;
    int seen;
    logic [DL2:0] lvl_before;
    logic [BW-1:0] exp_head;

    rst_n = 1'b0; rtr_nd = 1'b0; cpu_rd = 1'b0; rtr_dout = '0;

    //              rst nd  din              rd  rtr cnd lvl full dout
    vecs[0]  = mk(0, 0, '0,              0, 0, 0, 0, 0, '0);
    vecs[1]  = mk(0, 0, '0,              0, 0, 0, 0, 0, '0);
    vecs[2]  = mk(1, 1, 38'h2_1234_5678, 0, 1, 1, 1, 0, 38'h2_1234_5678);
    vecs[3]  = mk(1, 1, 38'h2_1234_5678, 0, 0, 1, 1, 0, 38'h2_1234_5678);
    vecs[4]  = mk(1, 0, '0,              0, 0, 1, 1, 0, 38'h2_1234_5678);
    vecs[5]  = mk(1, 0, '0,              0, 0, 1, 1, 0, 38'h2_1234_5678);
    vecs[6]  = mk(1, 0, '0,              1, 0, 0, 0, 0, '0);
    vecs[7]  = mk(1, 0, '0,              0, 0, 0, 0, 0, '0);
    vecs[8]  = mk(1, 0, '0,              1, 0, 0, 0, 0, '0);
    vecs[9]  = mk(1, 0, '0,              0, 0, 0, 0, 0, '0);
    vecs[10] = mk(1, 1, 38'h1_0bad_cafe, 0, 1, 1, 1, 0, 38'h1_0bad_cafe);
    vecs[11] = mk(1, 0, '0,              0, 0, 1, 1, 0, 38'h1_0bad_cafe);
    vecs[12] = mk(1, 0, '0,              0, 0, 1, 1, 0, 38'h1_0bad_cafe);
    vecs[13] = mk(1, 0, '0,              1, 0, 0, 0, 0, '0);
    vecs[14] = mk(1, 0, '0,              0, 0, 0, 0, 0, '0);

    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      rst_n = vecs[i].rst_n; rtr_nd = vecs[i].nd; rtr_dout = vecs[i].din; cpu_rd = vecs[i].rd;
      step();
      check($sformatf("vec%0d_rtr_rd", i), rtr_rd, vecs[i].e_rtr_rd);
      check($sformatf("vec%0d_cpu_nd", i), cpu_nd, vecs[i].e_cpu_nd);
      check($sformatf("vec%0d_level", i), level, vecs[i].e_level);
      check($sformatf("vec%0d_full", i), full, vecs[i].e_full);
      check($sformatf("vec%0d_dout", i), cpu_dout, vecs[i].e_dout);
    end

    // Fill: 8 flits acked, 9th held while full.
    do_reset();
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      push_flit(38'(i));
    end
    settle();
    check("fill_level", level, 4'd8);
    check("fill_full", full, 1'b1);
    check("fill_head", cpu_dout, 38'd0);
    rtr_nd = 1'b1; rtr_dout = 38'd8;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rtr_rd) seen++;
    end
    check("full_no_ack", seen, 0);
    // Pop edge N: no capture at N.
    cpu_rd = 1'b1;
    step();
    check("full_pop_level", level, 4'd7);
    check("full_pop_no_ack", rtr_rd, 1'b0);
    check("full_pop_nd_low", cpu_nd, 1'b0);
    cpu_rd = 1'b0;
    step();
    check("full_cap_ack", rtr_rd, 1'b1);
    check("full_cap_level", level, 4'd8);
    check("full_cap_full", full, 1'b1);
    check("full_cap_head", cpu_dout, 38'd1);
    rtr_dout = 38'd9;
    step();
    step();
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rtr_rd) seen++;
    end
    check("flit9_held", seen, 0);

    // Drain: cpu_rd held high 5 cycles gives exactly one pop.
    do_reset();
    push_flit(38'h100);
    push_flit(38'h101);
    push_flit(38'h102);
    settle();
    check("drain_level0", level, 4'd3);
    cpu_rd = 1'b1;
    step();
    check("drain_nd_low", cpu_nd, 1'b0);
    check("drain_level1", level, 4'd2);
    step();
    check("drain_nd_high", cpu_nd, 1'b1);
    step(); step(); step();
    check("drain_level_end", level, 4'd2);
    check("drain_head", cpu_dout, 38'h101);
    cpu_rd = 1'b0;
    step();
    check("drain_level_rel", level, 4'd2);

    // Wrap with coincident capture and pop on the same edge.
    do_reset();
    push_flit(38'h3_0000_0000);
    push_flit(38'h3_0000_0001);
    push_flit(38'h3_0000_0002);
    settle();
    for (int i = 3; i < 20; i++) begin
      exp_head = sb[0];
      check($sformatf("wrap_head%0d", i), cpu_dout, exp_head);
      check($sformatf("wrap_nd%0d", i), cpu_nd, 1'b1);
      lvl_before = level;
      rtr_nd = 1'b1; rtr_dout = 38'h3_0000_0000 | 38'(i); cpu_rd = 1'b1;
      step();
      check($sformatf("wrap_ack%0d", i), rtr_rd, 1'b1);
      check($sformatf("wrap_level%0d", i), level, lvl_before);
      check($sformatf("wrap_ndlow%0d", i), cpu_nd, 1'b0);
      void'(sb.pop_front());
      sb.push_back(38'h3_0000_0000 | 38'(i));
      settle();
    end
    while (sb.size() > 0) begin
      exp_head = sb.pop_front();
      check("wrap_tail_head", cpu_dout, exp_head);
      cpu_rd = 1'b1;
      step();
      cpu_rd = 1'b0;
      step();
    end
    check("wrap_empty", level, 4'd0);
    check("wrap_empty_nd", cpu_nd, 1'b0);

    // Reset during the ACK cycle with 4 flits stored.
    do_reset();
    push_flit(38'h50);
    push_flit(38'h51);
    push_flit(38'h52);
    settle();
    rtr_nd = 1'b1; rtr_dout = 38'h53;
    step();
    check("rst_pre_ack", rtr_rd, 1'b1);
    check("rst_pre_level", level, 4'd4);
    rst_n = 1'b0;
    step();
    check("rst_rtr_rd", rtr_rd, 1'b0);
    check("rst_cpu_nd", cpu_nd, 1'b0);
    check("rst_level", level, 4'd0);
    check("rst_full", full, 1'b0);
    check("rst_dout", cpu_dout, 38'd0);
    rst_n = 1'b1; rtr_nd = 1'b0;
    step();
    check("rst_after_level", level, 4'd0);
    sb.delete();
    push_flit(38'h77);
    check("rst_after_head", cpu_dout, 38'h77);
    check("rst_after_nd", cpu_nd, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
